// File: rtl/serial_restoring_div.sv
// serial_restoring_div
//
// Sequential restoring divider. Divides a 2N-bit unsigned dividend by an
// N-bit unsigned divisor. It decides one quotient bit per clock, MSB first,
// and exposes each bit on q_bit/q_valid as it is decided. A divide-by-zero
// or a quotient that would not fit in N bits is flagged and skips the
// iteration entirely.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, only honoured in IDLE
//   dividend   2N-bit unsigned dividend, captured with an accepted start
//   divisor    N-bit unsigned divisor, captured with an accepted start
//   busy       high while iterating
//   done       one-cycle pulse: quotient/remainder/dz/ovf valid
//   quotient   N-bit quotient, held until the next accepted start
//   remainder  N-bit remainder, held until the next accepted start
//   dz         divide-by-zero flag
//   ovf        quotient-overflow flag (dividend[2N-1:N] >= divisor)
//   q_bit      most recently decided quotient bit
//   q_valid    qualifier for q_bit
//   count_out  number of quotient bits completed, 0..N

module serial_restoring_div #(
    parameter int N = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2*N-1:0]           dividend,
    input  logic [N-1:0]             divisor,
    output logic                     busy,
    output logic                     done,
    output logic [N-1:0]             quotient,
    output logic [N-1:0]             remainder,
    output logic                     dz,
    output logic                     ovf,
    output logic                     q_bit,
    output logic                     q_valid,
    output logic [$clog2(N+1)-1:0]   count_out
);

    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Partial remainder carries one extra bit so the shifted value S fits.
    logic [N:0]   rem_r;
    logic [N-1:0] quo_r;
    logic [N-1:0] dvs_r;

    logic [N-1:0] div_hi;
    logic         err_dz;
    logic         err_ovf;
    logic [N+1:0] step;
    logic         qb;
    logic [N:0]   rem_nxt;
    logic [N-1:0] quo_nxt;
    logic         last_step;

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor and keep the difference only if
    // it did not borrow. Returns {quotient_bit, next_partial_remainder}.
    function automatic logic [N+1:0] restore_step(
        input logic [N:0]   r,
        input logic [N-1:0] q,
        input logic [N-1:0] d
    );
        logic [N:0]          s;
        logic signed [N+1:0] t;
        s = {r[N-1:0], q[N-1]};
        t = $signed({1'b0, s}) - $signed({2'b00, d});
        if (t >= 0)
            return {1'b1, t[N:0]};
        else
            return {1'b0, s};
    endfunction

    always_comb begin
        div_hi    = dividend[2*N-1:N];
        err_dz    = (divisor == '0);
        // Quotient fits in N bits only when the upper half is below the divisor.
        err_ovf   = (div_hi >= divisor);
        step      = restore_step(rem_r, quo_r, dvs_r);
        qb        = step[N+1];
        rem_nxt   = step[N:0];
        quo_nxt   = {quo_r[N-2:0], qb};
        last_step = (count_out == CW'(N-1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (err_dz || err_ovf)
                        state_nxt = DONE;
                    else
                        state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            q_bit     <= 1'b0;
            q_valid   <= 1'b0;
            count_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs_r     <= divisor;
                        dz        <= 1'b0;
                        ovf       <= 1'b0;
                        q_valid   <= 1'b0;
                        count_out <= '0;
                        quotient  <= '0;
                        remainder <= '0;
                        if (err_dz) begin
                            dz   <= 1'b1;
                            done <= 1'b1;
                        end else if (err_ovf) begin
                            ovf  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            rem_r <= {1'b0, div_hi};
                            quo_r <= dividend[N-1:0];
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_r     <= rem_nxt;
                    quo_r     <= quo_nxt;
                    q_bit     <= qb;
                    q_valid   <= 1'b1;
                    count_out <= count_out + CW'(1);
                    if (last_step) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_nxt;
                        remainder <= rem_nxt[N-1:0];
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    q_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
